// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-bit bus CPU: instruction field widths and
// the program loader control states.
package cpu_pkg;

    localparam int OP_SIZE  = 4;
    localparam int ARG_SIZE = 3;
    localparam int ARG_NUM  = 2;
    localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } loader_state_t;

endpackage

// File: rtl/prog_ram.sv
// Program word array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module prog_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Program store and fetch unit: host loads words over valid/ready, then the
// CPU is released from reset and fetched instructions follow done/branch.
module program_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic               load_done,
    input  logic               wr_valid,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               wr_ready,
    output logic               cpu_rst_n,
    input  logic               done,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branchaddress,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W:0]    count,
    output logic               overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    loader_state_t      state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d, count_inc;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d, rdata;
    logic               ovf_q, ovf_d;
    logic               run_q, run_d;
    logic               we, fetch, pc_last;

    assign wr_ready  = (state_q == LOAD) && (count_q < FULL_COUNT);
    assign we        = wr_ready && wr_valid;
    assign count_inc = count_q + {{ADDR_W{1'b0}}, we};
    assign pc_last   = ({1'b0, pc_q} == (count_q - 1'b1));

    prog_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (INSTR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .raddr (pc_d),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        run_d   = run_q;
        fetch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD;
                    count_d = '0;
                    pc_d    = '0;
                    ovf_d   = 1'b0;
                    run_d   = 1'b0;
                end
            end
            LOAD: begin
                count_d = count_inc;
                if (wr_valid && !wr_ready) begin
                    ovf_d = 1'b1;
                end
                if (load_done) begin
                    if (count_inc == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                        pc_d    = '0;
                        run_d   = 1'b1;
                        fetch   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_req) begin
                    state_d = LOAD;
                    count_d = '0;
                    pc_d    = '0;
                    ovf_d   = 1'b0;
                    run_d   = 1'b0;
                end else begin
                    fetch = 1'b1;
                    if (branch) begin
                        pc_d = branchaddress;
                    end else if (done) begin
                        pc_d = pc_last ? '0 : pc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A word written in the same cycle as the read of its address is forwarded.
    assign instr_d = !fetch ? '0 :
                     (we && (count_q[ADDR_W-1:0] == pc_d)) ? wr_data : rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ovf_q   <= ovf_d;
            run_q   <= run_d;
        end
    end

    assign cpu_rst_n   = run_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign count       = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: load, fetch, branch,
// overflow, bypass, empty load and asynchronous reset scenarios.
module tb_program_loader;
    import cpu_pkg::*;

    localparam int AW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_req, load_done, wr_valid, done, branch;
    logic [INSTR_W-1:0] wr_data;
    logic [AW-1:0]      branchaddress;
    logic               wr_ready, cpu_rst_n, overflow;
    logic [INSTR_W-1:0] instruction;
    logic [AW-1:0]      pc;
    logic [AW:0]        count;

    int n_checks = 0;
    int n_fail   = 0;

    program_loader dut (
        .clk           (clk),
        .rst           (rst),
        .load_req      (load_req),
        .load_done     (load_done),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .cpu_rst_n     (cpu_rst_n),
        .done          (done),
        .branch        (branch),
        .branchaddress (branchaddress),
        .instruction   (instruction),
        .pc            (pc),
        .count         (count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        load_req = 0; load_done = 0; wr_valid = 0; done = 0; branch = 0;
        wr_data = '0; branchaddress = '0;
        repeat (2) @(negedge clk);
        if (pc !== 4'd0) begin $display("[TB] FAIL reset_pc: got %0d expected 0", pc); n_fail++; end
        n_checks++;
        if (count !== 5'd0) begin $display("[TB] FAIL reset_count: got %0d expected 0", count); n_fail++; end
        n_checks++;
        if (instruction !== 10'h000) begin $display("[TB] FAIL reset_instr: got %h expected 000", instruction); n_fail++; end
        n_checks++;
        if ({overflow, wr_ready, cpu_rst_n} !== 3'b000) begin
            $display("[TB] FAIL reset_flags: got %b expected 000", {overflow, wr_ready, cpu_rst_n}); n_fail++;
        end
        n_checks++;
        rst = 1'b1;
    endtask

    task automatic test_load_run;
        logic [INSTR_W-1:0] prog [3];
        prog[0] = 10'h2A5; prog[1] = 10'h1C3; prog[2] = 10'h3FF;
        load_req = 1; tick; load_req = 0;
        if (wr_ready !== 1'b1) begin $display("[TB] FAIL load_ready: got %b expected 1", wr_ready); n_fail++; end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = prog[i]; tick;
        end
        wr_valid = 0;
        if (count !== 5'd3) begin $display("[TB] FAIL load_count: got %0d expected 3", count); n_fail++; end
        n_checks++;
        if (cpu_rst_n !== 1'b0) begin $display("[TB] FAIL load_cpu_held: got %b expected 0", cpu_rst_n); n_fail++; end
        n_checks++;
        load_done = 1; tick; load_done = 0;
        if (cpu_rst_n !== 1'b1) begin $display("[TB] FAIL run_cpu_rst_n: got %b expected 1", cpu_rst_n); n_fail++; end
        n_checks++;
        if (instruction !== 10'h2A5 || pc !== 4'd0) begin
            $display("[TB] FAIL run_first_fetch: got pc=%0d instr=%h expected pc=0 instr=2a5", pc, instruction); n_fail++;
        end
        n_checks++;
        if (wr_ready !== 1'b0) begin $display("[TB] FAIL run_ready: got %b expected 0", wr_ready); n_fail++; end
        n_checks++;
    endtask

    task automatic test_done;
        logic [AW-1:0]      exp_pc [4];
        logic [INSTR_W-1:0] exp_in [4];
        exp_pc[0] = 1; exp_pc[1] = 2; exp_pc[2] = 0; exp_pc[3] = 1;
        exp_in[0] = 10'h1C3; exp_in[1] = 10'h3FF; exp_in[2] = 10'h2A5; exp_in[3] = 10'h1C3;
        done = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (pc !== exp_pc[i] || instruction !== exp_in[i]) begin
                $display("[TB] FAIL done_step%0d: got pc=%0d instr=%h expected pc=%0d instr=%h",
                         i, pc, instruction, exp_pc[i], exp_in[i]);
                n_fail++;
            end
            n_checks++;
        end
        done = 0; tick;
        if (pc !== 4'd1 || instruction !== 10'h1C3) begin
            $display("[TB] FAIL done_hold: got pc=%0d instr=%h expected pc=1 instr=1c3", pc, instruction); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_branch;
        branch = 1; done = 1; branchaddress = 4'd2; tick;
        branch = 0; done = 0;
        if (pc !== 4'd2 || instruction !== 10'h3FF) begin
            $display("[TB] FAIL branch_wins: got pc=%0d instr=%h expected pc=2 instr=3ff", pc, instruction); n_fail++;
        end
        n_checks++;
        done = 1; tick; done = 0;
        if (pc !== 4'd0 || instruction !== 10'h2A5) begin
            $display("[TB] FAIL branch_wrap: got pc=%0d instr=%h expected pc=0 instr=2a5", pc, instruction); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_abort;
        load_req = 1; done = 1; tick; load_req = 0; done = 0;
        if (cpu_rst_n !== 1'b0) begin $display("[TB] FAIL abort_cpu_rst_n: got %b expected 0", cpu_rst_n); n_fail++; end
        n_checks++;
        if (pc !== 4'd0 || instruction !== 10'h000 || count !== 5'd0 || wr_ready !== 1'b1) begin
            $display("[TB] FAIL abort_state: got pc=%0d instr=%h count=%0d ready=%b expected 0 000 0 1",
                     pc, instruction, count, wr_ready);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1; wr_data = 10'h300 + 10'(i); tick;
        end
        if (count !== 5'd16 || wr_ready !== 1'b0 || overflow !== 1'b0) begin
            $display("[TB] FAIL full_state: got count=%0d ready=%b ovf=%b expected 16 0 0", count, wr_ready, overflow);
            n_fail++;
        end
        n_checks++;
        wr_data = 10'h155; tick; wr_valid = 0;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            $display("[TB] FAIL overflow_set: got ovf=%b count=%0d expected 1 16", overflow, count); n_fail++;
        end
        n_checks++;
        load_done = 1; tick; load_done = 0;
        if (instruction !== 10'h300 || cpu_rst_n !== 1'b1) begin
            $display("[TB] FAIL overflow_mem0: got instr=%h cpu=%b expected 300 1", instruction, cpu_rst_n); n_fail++;
        end
        n_checks++;
        branch = 1; branchaddress = 4'd15; tick; branch = 0;
        if (pc !== 4'd15 || instruction !== 10'h30F) begin
            $display("[TB] FAIL full_branch: got pc=%0d instr=%h expected 15 30f", pc, instruction); n_fail++;
        end
        n_checks++;
        done = 1; tick; done = 0;
        if (pc !== 4'd0 || instruction !== 10'h300) begin
            $display("[TB] FAIL full_wrap: got pc=%0d instr=%h expected 0 300", pc, instruction); n_fail++;
        end
        n_checks++;
        if (overflow !== 1'b1) begin $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); n_fail++; end
        n_checks++;
        load_req = 1; tick; load_req = 0;
        if (overflow !== 1'b0) begin $display("[TB] FAIL overflow_clear: got %b expected 0", overflow); n_fail++; end
        n_checks++;
    endtask

    task automatic test_bypass;
        wr_valid = 1; wr_data = 10'h2B7; load_done = 1; tick;
        wr_valid = 0; load_done = 0;
        if (instruction !== 10'h2B7 || pc !== 4'd0 || count !== 5'd1 || cpu_rst_n !== 1'b1) begin
            $display("[TB] FAIL bypass: got instr=%h pc=%0d count=%0d cpu=%b expected 2b7 0 1 1",
                     instruction, pc, count, cpu_rst_n);
            n_fail++;
        end
        n_checks++;
        done = 1; tick; done = 0;
        if (pc !== 4'd0 || instruction !== 10'h2B7) begin
            $display("[TB] FAIL single_wrap: got pc=%0d instr=%h expected 0 2b7", pc, instruction); n_fail++;
        end
        n_checks++;
        wr_valid = 1; wr_data = 10'h0AA; tick; wr_valid = 0;
        if (overflow !== 1'b0 || count !== 5'd1) begin
            $display("[TB] FAIL run_write_ignored: got ovf=%b count=%0d expected 0 1", overflow, count); n_fail++;
        end
        n_checks++;
        load_req = 1; tick; load_req = 0;
    endtask

    task automatic test_empty_done;
        load_done = 1; tick; load_done = 0;
        if (cpu_rst_n !== 1'b0 || wr_ready !== 1'b0 || count !== 5'd0) begin
            $display("[TB] FAIL empty_done: got cpu=%b ready=%b count=%0d expected 0 0 0", cpu_rst_n, wr_ready, count);
            n_fail++;
        end
        n_checks++;
        wr_valid = 1; wr_data = 10'h111; tick; wr_valid = 0;
        if (count !== 5'd0 || overflow !== 1'b0) begin
            $display("[TB] FAIL idle_ignore: got count=%0d ovf=%b expected 0 0", count, overflow); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_async_reset;
        load_req = 1; tick; load_req = 0;
        wr_valid = 1; wr_data = 10'h123; tick;
        wr_data = 10'h234; tick; wr_valid = 0;
        if (count !== 5'd2) begin $display("[TB] FAIL pre_reset_count: got %0d expected 2", count); n_fail++; end
        n_checks++;
        #2 rst = 1'b0;
        #1;
        if (count !== 5'd0 || wr_ready !== 1'b0 || pc !== 4'd0 || instruction !== 10'h000 ||
            overflow !== 1'b0 || cpu_rst_n !== 1'b0) begin
            $display("[TB] FAIL async_reset: got count=%0d ready=%b pc=%0d instr=%h ovf=%b cpu=%b expected all 0",
                     count, wr_ready, pc, instruction, overflow, cpu_rst_n);
            n_fail++;
        end
        n_checks++;
        @(negedge clk); rst = 1'b1;
        load_done = 1; wr_valid = 1; tick; load_done = 0; wr_valid = 0;
        if (cpu_rst_n !== 1'b0 || count !== 5'd0) begin
            $display("[TB] FAIL post_reset_idle: got cpu=%b count=%0d expected 0 0", cpu_rst_n, count); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset;
        test_load_run;
        test_done;
        test_branch;
        test_abort;
        test_overflow;
        test_bypass;
        test_empty_done;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/program_loader.md
# program_loader

Program store and fetch unit for the 3-bit bus CPU, sitting between an external host and `cpu_fsm`. The host writes a program of packed instructions (4-bit opcode plus two 3-bit arguments) into an internal array through a valid/ready handshake. The loader then releases the CPU from reset and serves `instruction` words in order, advancing on `done` and redirecting on `branch`. It is the writer-side counterpart of the read-only instruction memory and replaces it in the top level.

## Interface
- `OP_SIZE`, 4, opcode width
- `ARG_SIZE`, 3, width of one argument field
- `ARG_NUM`, 2, number of argument fields
- `INSTR_W`, OP_SIZE + ARG_NUM*ARG_SIZE (10), instruction width (derived)
- `DEPTH`, 16, program words; power of two
- `ADDR_W`, $clog2(DEPTH) (4), address width (derived)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `load_req`  in  1  host request to enter load mode
- `load_done`  in  1  host marks the end of the program
- `wr_valid`  in  1  host word valid
- `wr_data`  in  INSTR_W  host instruction word
- `wr_ready`  out  1  loader accepts a word
- `cpu_rst_n`  out  1  active-low reset to `cpu_fsm` and the datapath
- `done`  in  1  from `cpu_fsm`: current instruction retired
- `branch`  in  1  redirect fetch
- `branchaddress`  in  ADDR_W  branch target
- `instruction`  out  INSTR_W  current instruction to `cpu_fsm`
- `pc`  out  ADDR_W  address of `instruction`
- `count`  out  ADDR_W+1  words loaded in the current program
- `overflow`  out  1  sticky flag: a write was attempted while full

## Operation
- States: IDLE, LOAD, RUN. On reset the block enters IDLE with these outputs:
  - `pc`=0, `count`=0, `instruction`=0, `overflow`=0
  - `wr_ready`=0, `cpu_rst_n`=0
  - Array contents are not reset.
- IDLE:
  - `load_req` goes to LOAD. All other inputs are ignored.
- Entering LOAD, from IDLE or RUN:
  - Clears the write pointer, `count` and `overflow`. Sets `pc` and `instruction` to 0. Drives `cpu_rst_n`=0.
  - A `load_req` during RUN aborts execution immediately.
- LOAD:
  - `wr_ready` = (`count` < DEPTH).
  - A transfer happens when `wr_valid` and `wr_ready` are both high. It writes `mem[count]` = `wr_data` and increments `count`.
  - `wr_valid` with `wr_ready`=0 sets `overflow`. The word is dropped.
- `load_done` in LOAD:
  - A transfer in the same cycle is counted first.
  - Resulting `count`=0: go to IDLE.
  - Otherwise: go to RUN with `pc`=0 and `instruction`=`mem[0]`. If word 0 is written in that same cycle, `instruction` takes `wr_data` directly (bypass).
  - `load_req` is ignored while in LOAD.
- RUN:
  - `wr_ready`=0. Writes are ignored and do not set `overflow`.
  - Next `pc` priority: `load_req` (leave to LOAD) > `branch` (`branchaddress`) > `done` (increment) > hold.
  - Increment wraps: when `pc` = `count`-1, next `pc`=0.
  - Branch targets ≥ `count` are taken unchanged. The array returns stale contents; this is a program error and is not flagged.
- `instruction` is registered as `mem[next pc]`, so it is always consistent with `pc`.

## Timing
- Write latency: a word accepted at edge N is readable from edge N+1.
- `cpu_rst_n` is registered:
  - It rises on the edge that enters RUN.
  - It falls on the edge that leaves RUN.
- Fetch latency: `done` sampled high at edge N gives the new `pc`/`instruction` after edge N. Zero bubbles, so back-to-back `done` advances every cycle.
- `done` and `branch` arriving in the same cycle: the branch wins and `done` is consumed.
- Asynchronous `rst` at any point (mid-load, mid-run):
  - All state and outputs return to reset values immediately.
  - The CPU is held in reset until the next completed load.

## Structure
- Shared package `cpu_pkg`:
  - OP_SIZE, ARG_SIZE, ARG_NUM, INSTR_W
  - state enum `loader_state_t` {IDLE, LOAD, RUN}
- One natural sub-module: `prog_ram`. It is a DEPTH×INSTR_W array with one synchronous write port and one asynchronous read port. It has no reset.
- Control FSM, pointers, bypass and flags live in `program_loader`.

## Test plan
- Reset, then load 3 words `0x2A5`, `0x1C3`, `0x3FF`, then `load_done`:
  - `count`=3, state RUN.
  - `cpu_rst_n` rises one edge after `load_done`.
  - `instruction`=`0x2A5`, `pc`=0.
- In RUN with 3 words, pulse `done` 4 times: `pc` goes 1, 2, 0, 1 and `instruction` tracks `mem[pc]`.
- Assert `branch` and `done` together with `branchaddress`=2: `pc`=2, `instruction`=`0x3FF`. No increment occurs.
- Load 16 words, then hold `wr_valid` 1 more cycle:
  - `wr_ready`=0 after word 16.
  - `overflow`=1; `mem[0]` is unchanged.
  - The next `load_req` clears `overflow`.
- Assert `load_done` with zero words loaded: returns to IDLE and `cpu_rst_n` stays 0.
- Drop `rst` mid-load after 2 words, then release:
  - IDLE, `count`=0, all outputs at reset values.
  - A `load_req` in RUN drops `cpu_rst_n` on the next edge.
